// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame master: frame layout, register
// addresses carried in the frame's address field, and the FSM state encoding.
package spi_pkg;

  localparam int unsigned FRAME_WIDTH = 16;

  // Frame layout: address in the top nibble, payload below it
  localparam int unsigned ADDR_MSB    = 15;
  localparam int unsigned ADDR_LSB    = 12;
  localparam int unsigned ADDR_WIDTH  = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned PAYLOAD_MSB = 11;
  localparam int unsigned PAYLOAD_LSB = 0;

  // Target register addresses
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH0  = 4'h0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH1  = 4'h1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH2  = 4'h2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH3  = 4'h3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH4  = 4'h4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH5  = 4'h5;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH6  = 4'h6;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PWM_CH7  = 4'h7;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLK_DIV  = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

  // Extract the address field of a frame
  function automatic logic [ADDR_WIDTH-1:0] frame_addr(input logic [FRAME_WIDTH-1:0] frame);
    return frame[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/spi_halfbit_timer.sv
// SCK half-period timer: loads a count, decrements to zero without wrapping,
// and flags zero so the FSM can advance one phase per H = load_val+1 cycles.
module spi_halfbit_timer #(
  parameter int unsigned SCK_DIV_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [SCK_DIV_WIDTH-1:0] load_val,
  output logic                     tick_c
);

  logic [SCK_DIV_WIDTH-1:0] cnt_q;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - SCK_DIV_WIDTH'(1);
    end
  end

  // Phase ends on the cycle the counter sits at zero
  assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: sends one FRAME_WIDTH-bit frame MSB first per
// accepted request, with SETUP and GAP phases of one SCK half-period each.
// Optional readback of miso into rx_data is enabled by defining
// SPI_FRAME_MASTER_READBACK_EN; without it rx_data is tied to zero.
module spi_frame_master #(
  parameter int unsigned FRAME_WIDTH   = spi_pkg::FRAME_WIDTH,
  parameter int unsigned SCK_DIV_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_WIDTH-1:0]   tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [SCK_DIV_WIDTH-1:0] sck_div,
  output logic                     cs,
  output logic                     sck,
  output logic                     mosi,
  input  logic                     miso,
  output logic [FRAME_WIDTH-1:0]   rx_data,
  output logic                     busy,
  output logic                     done
);

  import spi_pkg::*;

  localparam int unsigned BIT_CNT_W = $clog2(FRAME_WIDTH);

  spi_state_e               state_q, state_d;
  logic                     cs_q, cs_d;
  logic                     sck_q, sck_d;
  logic                     done_q, done_d;
  logic                     tx_ready_q, tx_ready_d;
  logic                     busy_q, busy_d;
  logic [FRAME_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SCK_DIV_WIDTH-1:0] div_q, div_d;
  logic                     timer_load_c;
  logic [SCK_DIV_WIDTH-1:0] timer_val_c;
  logic                     timer_tick_c;

  spi_halfbit_timer #(
    .SCK_DIV_WIDTH(SCK_DIV_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .tick_c   (timer_tick_c)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    sck_d        = sck_q;
    tx_sh_d      = tx_sh_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    done_d       = 1'b0;
    timer_load_c = 1'b0;
    timer_val_c  = div_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d      = ST_SETUP;
          cs_d         = 1'b0;
          sck_d        = 1'b0;
          tx_sh_d      = tx_data;
          bit_cnt_d    = BIT_CNT_W'(FRAME_WIDTH - 1);
          div_d        = sck_div;
          timer_load_c = 1'b1;
          timer_val_c  = sck_div;
        end
      end
      ST_SETUP: begin
        if (timer_tick_c) begin
          state_d      = ST_SHIFT;
          sck_d        = 1'b1;
          timer_load_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (timer_tick_c) begin
          timer_load_c = 1'b1;
          if (sck_q) begin
            // Falling edge: present the next lower bit
            sck_d   = 1'b0;
            tx_sh_d = {tx_sh_q[FRAME_WIDTH-2:0], 1'b0};
          end else if (bit_cnt_q == '0) begin
            state_d = ST_GAP;
            cs_d    = 1'b1;
            tx_sh_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            sck_d     = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (timer_tick_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_sh_q    <= tx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
    end
  end

  assign cs       = cs_q;
  assign sck      = sck_q;
  assign mosi     = tx_sh_q[FRAME_WIDTH-1];
  assign done     = done_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

`ifdef SPI_FRAME_MASTER_READBACK_EN
  logic [FRAME_WIDTH-1:0] rx_sh_q;
  logic [FRAME_WIDTH-1:0] rx_data_q;
  logic                   rx_sample_c;
  logic                   rx_load_c;

  // Sample on every sck rising edge; publish the frame on the done cycle
  assign rx_sample_c = timer_tick_c &&
                       ((state_q == ST_SETUP) ||
                        ((state_q == ST_SHIFT) && !sck_q && (bit_cnt_q != '0)));
  assign rx_load_c   = timer_tick_c && (state_q == ST_GAP);

  // Readback shift register and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      if (rx_sample_c) begin
        rx_sh_q <= {rx_sh_q[FRAME_WIDTH-2:0], miso};
      end
      if (rx_load_c) begin
        rx_data_q <= rx_sh_q;
      end
    end
  end

  assign rx_data = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: stimulus pushes expected frames,
// a negedge monitor reconstructs each frame from the pins and checks it on done.
module tb_spi_frame_master;

  localparam int unsigned FW = 16;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] sck_div = '0;
  logic          cs, sck, mosi, miso;
  logic [FW-1:0] rx_data;
  logic          busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [FW-1:0] frame;
    int            h;
    logic [FW-1:0] rx;
  } exp_t;

  exp_t exp_q[$];

  spi_frame_master #(.FRAME_WIDTH(FW), .SCK_DIV_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sck_div  (sck_div),
    .cs       (cs),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Loopback so readback must return the transmitted frame
  assign miso = mosi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [FW-1:0] exp_rx(input logic [FW-1:0] f);
`ifdef SPI_FRAME_MASTER_READBACK_EN
    return f;
`else
    return '0;
`endif
  endfunction

  // ---------------- monitor ----------------
  logic [FW-1:0] bits;
  int  nbits, cs_low_cnt, cs_high_run, hi_run, lo_run;
  int  hi_min, hi_max, lo_min, lo_max, lat;
  bit  lat_active;
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bits = '0; nbits = 0; cs_low_cnt = 0; cs_high_run = 0;
      hi_run = 0; lo_run = 0; lat = 0; lat_active = 0;
      prev_sck = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0; prev_done = 1'b0;
    end else begin
      if (lat_active) lat++;

      // sck edges and phase widths; mosi captured on rising edges
      if (sck && !prev_sck) begin
        bits = {bits[FW-2:0], mosi};
        nbits++;
        if (lo_run > 0) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        hi_run = 1;
      end else if (sck) begin
        hi_run++;
      end else if (prev_sck) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run = 1;
      end else if (lo_run > 0) begin
        lo_run++;
      end

      // cs framing; between back-to-back frames cs is high for GAP plus the done cycle
      if (!cs && prev_cs) begin
        if (prev_done && exp_q.size() > 0)
          check("b2b_cs_high_cycles", cs_high_run, exp_q[0].h + 1);
        cs_low_cnt = 1; nbits = 0; bits = '0; lo_run = 0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
      end else if (!cs) begin
        cs_low_cnt++;
      end else if (!prev_cs) begin
        cs_high_run = 1;
      end else begin
        cs_high_run++;
      end

      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", bits, e.frame);
          check("bit_count", nbits, FW);
          check("cs_low_cycles", cs_low_cnt, (1 + 2 * FW) * e.h);
          check("sck_high_min", hi_min, e.h);
          check("sck_high_max", hi_max, e.h);
          check("sck_low_min", lo_min, e.h);
          check("sck_low_max", lo_max, e.h);
          check("accept_to_done", lat, (2 + 2 * FW) * e.h + 1);
          check("rx_data", rx_data, e.rx);
          check("tx_ready_in_done", tx_ready, 1);
        end
        lat_active = 0;
      end

      // busy rises in the cycle after the accept cycle
      if (busy && !prev_busy) begin
        lat = 1;
        lat_active = 1;
      end

      prev_sck  = sck;
      prev_cs   = cs;
      prev_busy = busy;
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [FW-1:0] f, input logic [DW-1:0] d, input bit push);
    int n = 0;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("send_ready_timeout", 0, 1);
    tx_data  = f;
    sck_div  = d;
    tx_valid = 1'b1;
    if (push) exp_q.push_back('{f, int'(d) + 1, exp_rx(f)});
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int done_cnt;

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_data", rx_data, 0);
    #1 rst = 1'b0;
    #1 check("tx_ready_before_edge", tx_ready, 0);
    @(negedge clk);
    check("tx_ready_after_edge", tx_ready, 1);

    // H=1 and H=4 with the same frame
    send(16'h83FF, 4'd0, 1);
    wait_done(200);
    send(16'h83FF, 4'd3, 1);
    wait_done(400);

    // Back-to-back with tx_valid held; second accept in the first done cycle
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    tx_data  = 16'h1234;
    sck_div  = 4'd1;
    tx_valid = 1'b1;
    exp_q.push_back('{16'h1234, 2, exp_rx(16'h1234)});
    @(negedge clk);
    tx_data = 16'h8005;
    exp_q.push_back('{16'h8005, 2, exp_rx(16'h8005)});
    n = 0;
    while (!(done && tx_ready) && n < 300) begin @(negedge clk); n++; end
    check("b2b_ready_in_done", done && tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_second_accept_busy", busy, 1);
    wait_done(300);

    // Input changes mid-frame must not disturb the frame in flight
    send(16'h5A3C, 4'd1, 1);
    repeat (10) @(negedge clk);
    tx_data = 16'hFFFF;
    sck_div = 4'd7;
    wait_done(300);

    // Readback loop
    send(16'hA5C3, 4'd0, 1);
    wait_done(200);

    // Abort at bit 7 (H=2: bit 7 high phase is cycles 35-36 after the accept cycle)
    send(16'hF0F0, 4'd1, 0);
    repeat (34) @(negedge clk);
    check("abort_pre_sck_high", sck, 1);
    check("abort_pre_cs_low", cs, 0);
    #1 rst = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_ready", tx_ready, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("abort_tx_ready_before_edge", tx_ready, 0);
    @(negedge clk);
    check("abort_tx_ready_after_edge", tx_ready, 1);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);

    // One more frame after the abort
    send(16'h0F81, 4'd0, 1);
    wait_done(200);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run time
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
